// File: rtl/led_status_ctrl.sv
// led_status_ctrl
// Per-LED mode registers (OFF/ON/SLOW/FAST/ACT/ACT_INV) driving a registered
// LED request vector toward a downstream LED subsystem. A shared 1 ms tick
// feeds two phase bits (1 Hz and 4 Hz), so every blinking LED stays in step.
// Activity strobes are stretched to STRETCH_MS ticks per LED. Nothing is
// driven until the downstream subsystem reports ready (lamp test done).
//
// Handshake: sub_ready is a level, not a pulse. The first cycle it is seen
// high moves WAIT->RUN and starts the tick counter from zero. The first cycle
// it is seen low moves RUN->WAIT and clears all counters. cfg_wr is a
// single-cycle strobe that needs no acknowledge: it is accepted or rejected in
// the same cycle, and a rejection is flagged by cfg_err on the following cycle.

module led_status_ctrl #(
  parameter int CLK_FREQ   = 125000000,
  parameter int NUM_LED    = 4,
  parameter int STRETCH_MS = 50,
  parameter int RESET_MODE = 0,
  // Index port width; widened only when out-of-range indices must be drivable.
  parameter int IDX_W      = $clog2(NUM_LED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_mode,
  input  logic [NUM_LED-1:0] act,
  input  logic               sub_ready,
  output logic [NUM_LED-1:0] led_req,
  output logic               cfg_err
);

  // Clock cycles per 1 ms tick and the width of the counter that spans them.
  localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STR_W    = $clog2(STRETCH_MS + 1);

  // Mode encoding.
  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_SLOW    = 3'd2;
  localparam logic [2:0] MODE_FAST    = 3'd3;
  localparam logic [2:0] MODE_ACT     = 3'd4;
  localparam logic [2:0] MODE_ACT_INV = 3'd5;

  // An out-of-range reset mode is folded to OFF so the registers only ever
  // hold legal codes.
  localparam logic [2:0] RST_MODE =
    (RESET_MODE >= 0 && RESET_MODE <= 5) ? 3'(RESET_MODE) : MODE_OFF;

  // Half-periods of the blink phases, in ticks.
  localparam logic [8:0] SLOW_LAST = 9'd499;  // 500 ticks -> 1 Hz
  localparam logic [6:0] FAST_LAST = 7'd124;  // 125 ticks -> 4 Hz

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 run_en;   // stretch counters may load/decrement
  logic                 led_en;   // led_req may be non-zero next cycle

  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic [8:0]           slow_cnt;
  logic [6:0]           fast_cnt;
  logic                 slow_ph;
  logic                 fast_ph;

  logic [2:0]           mode_q    [NUM_LED];
  logic [STR_W-1:0]     stretch_q [NUM_LED];

  logic                 idx_ok;
  logic                 mode_ok;
  logic                 wr_ok;
  logic                 wr_bad;
  logic [NUM_LED-1:0]   led_d;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and the enables it grants to the datapath.
  always_comb begin
    state_d = state_q;
    run_en  = 1'b0;
    led_en  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (sub_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        led_en = 1'b1;
        if (sub_ready) begin
          run_en = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // The tick fires on the cycle the divider wraps; never while not ready.
  assign tick = sub_ready && (tick_cnt == TICK_W'(TICK_DIV - 1));

  // 1 ms divider: held at zero whenever the subsystem is not ready, so the
  // first ready cycle is count zero and blink phase is deterministic.
  always_ff @(posedge clk) begin
    if (rst || !sub_ready) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Shared blink phases, advanced by the tick and cleared with the divider.
  always_ff @(posedge clk) begin
    if (rst || !sub_ready) begin
      slow_cnt <= '0;
      fast_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_ph  <= 1'b0;
    end else if (tick) begin
      if (slow_cnt == SLOW_LAST) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + 9'd1;
      end
      if (fast_cnt == FAST_LAST) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + 7'd1;
      end
    end
  end

  // Write qualification: the index is compared at full width so an index
  // beyond the LED count is rejected rather than aliased onto a real LED.
  always_comb begin
    idx_ok  = (int'(cfg_idx) < NUM_LED);
    mode_ok = (cfg_mode <= MODE_ACT_INV);
    wr_ok   = cfg_wr && idx_ok && mode_ok;
    wr_bad  = cfg_wr && !(idx_ok && mode_ok);
  end

  // Mode registers: written in any state, untouched by a rejected write.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_LED; n++) begin
      if (rst) begin
        mode_q[n] <= RST_MODE;
      end else if (wr_ok && (int'(cfg_idx) == n)) begin
        mode_q[n] <= cfg_mode;
      end
    end
  end

  // One-cycle error pulse for the write rejected in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= wr_bad;
    end
  end

  // Activity stretch per LED, independent of mode: a strobe (re)loads the full
  // length and wins over a same-cycle tick; otherwise count down to zero.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_LED; n++) begin
      if (rst || !run_en) begin
        stretch_q[n] <= '0;
      end else if (act[n]) begin
        stretch_q[n] <= STR_W'(STRETCH_MS);
      end else if (tick && (stretch_q[n] != '0)) begin
        stretch_q[n] <= stretch_q[n] - STR_W'(1);
      end
    end
  end

  // Per-LED drive decode; the live strobe is OR-ed in so activity shows up
  // on the cycle right after the strobe.
  always_comb begin
    led_d = '0;
    for (int n = 0; n < NUM_LED; n++) begin
      case (mode_q[n])
        MODE_OFF:     led_d[n] = 1'b0;
        MODE_ON:      led_d[n] = 1'b1;
        MODE_SLOW:    led_d[n] = slow_ph;
        MODE_FAST:    led_d[n] = fast_ph;
        MODE_ACT:     led_d[n] = act[n] || (stretch_q[n] != '0);
        MODE_ACT_INV: led_d[n] = !(act[n] || (stretch_q[n] != '0));
        default:      led_d[n] = 1'b0;
      endcase
    end
    if (!led_en) begin
      led_d = '0;
    end
  end

  // Registered LED request toward the downstream subsystem.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_req <= '0;
    end else begin
      led_req <= led_d;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl
// Directed bench for led_status_ctrl with a 10-cycle tick, four LEDs and a
// 3-tick stretch. All LEDs reset to ACT mode. Inputs change 1 time unit after
// a rising edge and outputs are read at the same point, so every value read
// reflects the edge just taken. k counts edges from the first edge that
// samples sub_ready high (that edge is k=0).

module tb_led_status_ctrl;

  localparam int NUM_LED = 4;
  localparam int IDX_W   = 3;

  // ---------------------------------------------------------------- clock/reset
  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_wr;
  logic [IDX_W-1:0]   cfg_idx;
  logic [2:0]         cfg_mode;
  logic [NUM_LED-1:0] act;
  logic               sub_ready;
  logic [NUM_LED-1:0] led_req;
  logic               cfg_err;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .CLK_FREQ   (10000),
    .NUM_LED    (NUM_LED),
    .STRETCH_MS (3),
    .RESET_MODE (4),
    .IDX_W      (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_idx   (cfg_idx),
    .cfg_mode  (cfg_mode),
    .act       (act),
    .sub_ready (sub_ready),
    .led_req   (led_req),
    .cfg_err   (cfg_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int                 vec_cnt = 0;
  int                 err_cnt = 0;
  int                 k       = 0;
  logic [NUM_LED-1:0] exp_q[$];
  int                 at_k_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [2:0] m);
    cfg_wr   = 1'b1;
    cfg_idx  = idx;
    cfg_mode = m;
    step();
    cfg_wr   = 1'b0;
  endtask

  task automatic pulse_act(input logic [NUM_LED-1:0] a);
    act = a;
    step();
    act = '0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [NUM_LED-1:0] e;
    int                 t;

    rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_mode = '0;
    act = '0;   sub_ready = 1'b0;
    step();
    step();
    check("reset_led", led_req, 4'b0000);
    check("reset_err", cfg_err, 1'b0);
    rst = 1'b0;

    // Writes while waiting for the subsystem: LED1 ON, LED0 SLOW, LED2 FAST.
    cfg_write(3'd1, 3'd1);
    check("wait_wr_err", cfg_err, 1'b0);
    cfg_write(3'd0, 3'd2);
    cfg_write(3'd2, 3'd3);
    step();
    check("wait_led", led_req, 4'b0000);

    // Subsystem ready: ON appears two edges after sub_ready is first seen.
    sub_ready = 1'b1;
    step();
    k = 0;
    check("rise_k0", led_req, 4'b0000);
    step();
    check("rise_k1", led_req, 4'b0010);

    // Blink timeline: slow toggles at k=5000/10000, fast every 1250.
    at_k_q.push_back(1249);  exp_q.push_back(4'b0010);
    at_k_q.push_back(1250);  exp_q.push_back(4'b0110);
    at_k_q.push_back(2499);  exp_q.push_back(4'b0110);
    at_k_q.push_back(2500);  exp_q.push_back(4'b0010);
    at_k_q.push_back(4999);  exp_q.push_back(4'b0110);
    at_k_q.push_back(5000);  exp_q.push_back(4'b0011);
    at_k_q.push_back(9999);  exp_q.push_back(4'b0111);
    at_k_q.push_back(10000); exp_q.push_back(4'b0010);
    while (exp_q.size() > 0) begin
      t = at_k_q.pop_front();
      e = exp_q.pop_front();
      run_to(t);
      check($sformatf("blink_k%0d", t), led_req, e);
    end

    // Single act on LED3 (ACT) at divider count 0: on for 30 edges.
    run_to(10009);
    check("act_pre", led_req, 4'b0010);
    pulse_act(4'b1000);
    check("act_first", led_req, 4'b1010);
    run_to(10039);
    check("act_last_on", led_req, 4'b1010);
    run_to(10040);
    check("act_off", led_req, 4'b0010);

    // Retrigger after the first tick extends to 3 ticks from the retrigger.
    run_to(10049);
    pulse_act(4'b1000);
    run_to(10064);
    pulse_act(4'b1000);
    run_to(10080);
    check("retrig_extended", led_req, 4'b1010);
    run_to(10089);
    check("retrig_last_on", led_req, 4'b1010);
    run_to(10090);
    check("retrig_off", led_req, 4'b0010);

    // Same-cycle write to ACT and strobe on LED0: both take effect.
    run_to(10099);
    cfg_wr = 1'b1; cfg_idx = 3'd0; cfg_mode = 3'd4; act = 4'b0001;
    step();
    cfg_wr = 1'b0; act = 4'b0000;
    check("wr_act_old_mode", led_req, 4'b0010);
    check("wr_act_err", cfg_err, 1'b0);
    step();
    check("wr_act_new_mode", led_req, 4'b0011);
    run_to(10129);
    check("wr_act_last_on", led_req, 4'b0011);
    run_to(10130);
    check("wr_act_off", led_req, 4'b0010);

    // Rejected writes: bad mode, bad mode on a visible LED, index past range.
    run_to(10139);
    cfg_write(3'd2, 3'd7);
    check("bad_mode_err", cfg_err, 1'b1);
    step();
    check("bad_mode_err_clr", cfg_err, 1'b0);
    cfg_write(3'd1, 3'd6);
    check("bad_mode6_err", cfg_err, 1'b1);
    step();
    check("bad_mode6_err_clr", cfg_err, 1'b0);
    check("bad_mode6_kept", led_req, 4'b0010);
    cfg_write(3'd5, 3'd0);
    check("bad_idx_err", cfg_err, 1'b1);
    step();
    check("bad_idx_err_clr", cfg_err, 1'b0);
    step();
    check("bad_idx_kept", led_req, 4'b0010);

    // One-cycle reset mid-blink with a stretch running and a write pending.
    run_to(10150);
    pulse_act(4'b1000);
    step();
    check("pre_rst", led_req, 4'b1010);
    rst = 1'b1; cfg_wr = 1'b1; cfg_idx = 3'd1; cfg_mode = 3'd1;
    step();
    rst = 1'b0; cfg_wr = 1'b0;
    check("rst_mid_led", led_req, 4'b0000);
    check("rst_mid_err", cfg_err, 1'b0);
    step();
    check("post_rst_wait", led_req, 4'b0000);
    step();
    check("post_rst_modes", led_req, 4'b0000);
    pulse_act(4'b0010);
    check("post_rst_act", led_req, 4'b0010);

    // ACT_INV on LED0: lit when idle, dark on activity.
    cfg_write(3'd0, 3'd5);
    check("actinv_wr_err", cfg_err, 1'b0);
    step();
    check("actinv_idle", led_req, 4'b0011);
    pulse_act(4'b0001);
    check("actinv_act", led_req, 4'b0010);

    // sub_ready falls: one more cycle of drive, then dark; act ignored.
    cfg_write(3'd1, 3'd1);
    step();
    check("on_again", led_req, 4'b0010);
    sub_ready = 1'b0;
    step();
    check("fall_k1", led_req, 4'b0010);
    step();
    check("fall_k2", led_req, 4'b0000);
    pulse_act(4'b1111);
    step();
    check("wait_act_ignored", led_req, 4'b0000);
    sub_ready = 1'b1;
    step();
    check("rerise_k0", led_req, 4'b0000);
    step();
    check("rerise_k1", led_req, 4'b0011);

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter NUM_LED, default 4, meaning number of LEDs controlled (range 2..16).
REQ-003 SHALL have parameter STRETCH_MS, default 50, meaning activity pulse-stretch length in ms ticks (1..1023).
REQ-004 SHALL have parameter RESET_MODE, default 0, meaning mode loaded into every LED register at reset.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port cfg_wr, input, 1, single-cycle mode write strobe.
REQ-008 SHALL have port cfg_idx, input, $clog2(NUM_LED), target LED index.
REQ-009 SHALL have port cfg_mode, input, 3, mode code to write.
REQ-010 SHALL have port act, input, NUM_LED, per-LED activity strobes, any width.
REQ-011 SHALL have port sub_ready, input, 1, ready from the downstream LED subsystem (lamp test finished).
REQ-012 SHALL have port led_req, output, NUM_LED, registered LED drive to the downstream led_in.
REQ-013 SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected write.

Function
REQ-014 SHALL derive a 1 ms tick: counter 0..CLK_FREQ/1000-1; tick asserts for 1 cycle on wrap.
REQ-015 SHALL keep shared phase bits: slow toggles every 500 ticks (1 Hz); fast toggles every 125 ticks (4 Hz); all LEDs in a blink mode stay phase-aligned.
REQ-016 SHALL decode modes as 0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 ACT, 5 ACT_INV; codes 6-7 are invalid.
REQ-017 SHALL drive the ACT LED bit high while its stretch counter is nonzero; ACT_INV drives the inverse.
REQ-018 SHALL, on act[n]=1 in cycle N, load stretch[n]=STRETCH_MS in cycle N+1.
- This load is independent of mode.
- A retrigger reloads the counter to full.
REQ-019 SHALL decrement a nonzero stretch[n] by 1 on each tick; a load takes priority over a decrement in the same cycle.
REQ-020 SHALL register led_req: it reflects the mode/phase/stretch state of the previous cycle (1-cycle latency).
- act[n] at N -> led_req[n] high at N+1 in ACT mode (combined act-or-stretch term).
REQ-021 SHALL accept cfg_wr with cfg_idx<NUM_LED and cfg_mode<=5.
- Writes mode[cfg_idx] at the next edge.
- The new mode is visible on led_req one cycle later.
REQ-022 SHALL reject cfg_wr with cfg_idx>=NUM_LED or cfg_mode>=6.
- No register changes.
- cfg_err=1 for exactly the following cycle.
REQ-023 SHALL gate on sub_ready via two states, WAIT and RUN:
- WAIT (sub_ready=0): led_req=0; tick counter, phase bits and stretch counters held at 0; act ignored; cfg writes still accepted.
- WAIT->RUN on the first cycle sub_ready=1; tick counting starts from 0 there, so blink phase is deterministic.
- RUN->WAIT when sub_ready falls: counters clear on the next cycle and led_req=0 the cycle after.
REQ-024 SHALL apply a write and an act strobe on the same LED in the same cycle both: the new mode plus the reloaded stretch.
REQ-025 SHALL keep stretch counters at width $clog2(STRETCH_MS+1); they saturate at 0 and never wrap.

Reset
REQ-026 SHALL, while rst=1, set:
- state=WAIT;
- all counters, phase bits and stretch counters to 0;
- mode[n]=RESET_MODE for every n (an invalid RESET_MODE behaves as OFF);
- led_req=0 and cfg_err=0.
REQ-027 SHALL give rst priority over all other inputs.
- Reset mid-operation discards pending stretches and writes.
- led_req=0 on the cycle after rst is sampled.

Verification
REQ-028 Bench parameters SHALL be CLK_FREQ=10000 (tick every 10 clk), NUM_LED=4, STRETCH_MS=3.
REQ-029 Scenario: reset, sub_ready=0, write idx1 mode ON -> led_req=0000; raise sub_ready -> led_req=0010 two cycles later.
REQ-030 Scenario: mode0=SLOW, sub_ready rises at cycle T -> led_req[0] toggles at T+5001 and T+10001.
- With mode2=FAST added, led_req[2] toggles every 1250 cycles, aligned to the same start.
REQ-031 Scenario: mode3=ACT, single act[3] pulse -> led_req[3] high next cycle, low after exactly 3 ticks.
- A retrigger at tick 2 extends the on-time to 3 ticks from the retrigger.
REQ-032 Scenario: cfg_wr idx=2 mode=7, then idx=5 with NUM_LED=4 (bench width widened) -> cfg_err pulses 1 cycle each; modes unchanged.
REQ-033 Scenario: rst asserted for 1 cycle mid-blink with stretch active -> led_req=0000 next cycle; all modes=RESET_MODE; stretches cleared.
